// File: rtl/rc_state_serializer_pkg.sv
// Shared parameters for the RcState readout path: lane geometry, index/frame widths
// and the serializer's two-state control encoding.
package rc_state_serializer_pkg;
    localparam int unsigned NO      = 3;
    localparam int unsigned WR      = 8;
    localparam int unsigned IDX_W   = $clog2(NO);
    localparam int unsigned FRAME_W = 16;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } rc_state_e;
endpackage

// File: rtl/rc_state_fifo.sv
// Generic synchronous FIFO with head-of-queue read data, occupancy count and
// full/empty flags; storage is not reset, control state is.
module rc_state_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/rc_state_serializer.sv
// Buffers whole RcState vectors and streams them lane by lane to the host,
// tagging each word with lane index, last flag and a completed-frame counter.
module rc_state_serializer
    import rc_state_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iValid_AS_RcState,
    output logic                 oReady_AS_RcState,
    input  logic [NO*WR-1:0]     iData_AS_RcState,
    output logic                 oValid_BM_RcWord,
    input  logic                 iReady_BM_RcWord,
    output logic [WR-1:0]        oData_BM_RcWord,
    output logic                 oLast_BM_RcWord,
    output logic [IDX_W-1:0]     oIndex_BM_RcWord,
    output logic [FRAME_W-1:0]   oFrame_BM_RcWord
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    rc_state_e          r_state;
    rc_state_e          w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [FRAME_W-1:0] r_frame;
    logic [NO*WR-1:0]   w_head;
    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_hs;
    logic               w_last;
    logic               w_pop;
    logic [WR-1:0]      w_lane;

    rc_state_fifo #(
        .WIDTH (NO*WR),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (iCLK),
        .i_rst_n (iRST),
        .i_push  (w_push),
        .i_data  (iData_AS_RcState),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ready depends only on registered occupancy, never on either valid/ready input.
    assign oReady_AS_RcState = ~w_full;
    assign w_push            = iValid_AS_RcState & oReady_AS_RcState;
    assign oValid_BM_RcWord  = (r_state == ST_SEND) & ~w_empty;
    assign w_hs              = oValid_BM_RcWord & iReady_BM_RcWord;
    assign w_last            = (r_idx == IDX_W'(NO - 1));
    assign w_pop             = w_hs & w_last;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_push) w_state_nxt = ST_SEND;
            ST_SEND: if (w_pop && !w_push && (w_count == CW'(1))) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_idx   <= '0;
            r_frame <= '0;
        end else if (w_pop) begin
            r_idx   <= '0;
            r_frame <= r_frame + FRAME_W'(1);
        end else if (w_hs) begin
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

    always_comb begin
        w_lane = '0;
        for (int unsigned i = 0; i < NO; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_lane = w_head[i*WR +: WR];
            end
        end
    end

    assign oData_BM_RcWord  = oValid_BM_RcWord ? w_lane : '0;
    assign oLast_BM_RcWord  = oValid_BM_RcWord & w_last;
    assign oIndex_BM_RcWord = r_idx;
    assign oFrame_BM_RcWord = r_frame;
endmodule

// File: tb/tb_rc_state_serializer.sv
// Self-checking bench for rc_state_serializer: vector table, hand sequences for
// fill/stall/reset/wrap, and randomized traffic against a queue-based model.
module tb_rc_state_serializer;
    import rc_state_serializer_pkg::*;

    logic                iCLK = 1'b0;
    logic                iRST = 1'b0;
    logic                iValid = 1'b0;
    logic                iReady = 1'b0;
    logic [NO*WR-1:0]    iData = '0;
    logic                oReady;
    logic                oValid;
    logic [WR-1:0]       oData;
    logic                oLast;
    logic [IDX_W-1:0]    oIndex;
    logic [FRAME_W-1:0]  oFrame;

    rc_state_serializer #(.DEPTH(4)) dut (
        .iCLK              (iCLK),
        .iRST              (iRST),
        .iValid_AS_RcState (iValid),
        .oReady_AS_RcState (oReady),
        .iData_AS_RcState  (iData),
        .oValid_BM_RcWord  (oValid),
        .iReady_BM_RcWord  (iReady),
        .oData_BM_RcWord   (oData),
        .oLast_BM_RcWord   (oLast),
        .oIndex_BM_RcWord  (oIndex),
        .oFrame_BM_RcWord  (oFrame)
    );

    always #5 iCLK = ~iCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of whole vectors, the lane being shown, frames done.
    logic [23:0] mq[$];
    int unsigned midx   = 0;
    logic [15:0] mframe = '0;

    typedef struct {
        logic        v;
        logic [23:0] d;
        logic        r;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  ei;
        logic        el;
        logic        er;
        logic [15:0] ef;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lane_of(input logic [23:0] v, input int unsigned i);
        logic [23:0] s;
        s = v >> (8 * i);
        return s[7:0];
    endfunction

    task automatic check_model(input string tag);
        bit v;
        v = (mq.size() != 0);
        chk({tag, " valid"}, 32'(oValid), 32'(v));
        chk({tag, " data"},  32'(oData),  v ? 32'(lane_of(mq[0], midx)) : 32'd0);
        chk({tag, " index"}, 32'(oIndex), midx);
        chk({tag, " last"},  32'(oLast),  32'(v && midx == NO - 1));
        chk({tag, " ready"}, 32'(oReady), 32'(mq.size() < 4));
        chk({tag, " frame"}, 32'(oFrame), 32'(mframe));
    endtask

    task automatic model_reset();
        mq.delete();
        midx   = 0;
        mframe = '0;
    endtask

    task automatic cycle(input logic v, input logic [23:0] d, input logic r,
                         input bit do_chk, input string tag);
        bit push, hs, pop;
        logic [23:0] drop;
        iValid = v;
        iData  = d;
        iReady = r;
        push = v && (mq.size() < 4);
        hs   = (mq.size() > 0) && r;
        pop  = hs && (midx == NO - 1);
        @(posedge iCLK);
        if (pop) begin
            drop   = mq.pop_front();
            midx   = 0;
            mframe = mframe + 16'd1;
        end else if (hs) begin
            midx++;
        end
        if (push) mq.push_back(d);
        #1;
        if (do_chk) check_model(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && mq.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b1, tag);
        chk({tag, " drained"}, 32'(oValid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 24'h332211, 1'b1, 1'b1, 8'h11, 2'd0, 1'b0, 1'b1, 16'd0};
        tbl[1]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h22, 2'd1, 1'b0, 1'b1, 16'd0};
        tbl[2]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1, 1'b1, 16'd0};
        tbl[3]  = '{1'b0, 24'h000000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 16'd1};
        tbl[4]  = '{1'b1, 24'h665544, 1'b0, 1'b1, 8'h44, 2'd0, 1'b0, 1'b1, 16'd1};
        tbl[5]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h55, 2'd1, 1'b0, 1'b1, 16'd1};
        for (int i = 6; i <= 10; i++)
            tbl[i] = '{1'b0, 24'h000000, 1'b0, 1'b1, 8'h55, 2'd1, 1'b0, 1'b1, 16'd1};
        tbl[11] = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h66, 2'd2, 1'b1, 1'b1, 16'd1};
        tbl[12] = '{1'b0, 24'h000000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 16'd2};

        // Reset values
        #12;
        model_reset();
        check_model("reset");
        iRST = 1'b1;

        // Single vector then host stall
        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0, "tbl");
            chk($sformatf("tbl[%0d] valid", i), 32'(oValid), 32'(tbl[i].ev));
            chk($sformatf("tbl[%0d] data", i),  32'(oData),  32'(tbl[i].ed));
            chk($sformatf("tbl[%0d] index", i), 32'(oIndex), 32'(tbl[i].ei));
            chk($sformatf("tbl[%0d] last", i),  32'(oLast),  32'(tbl[i].el));
            chk($sformatf("tbl[%0d] ready", i), 32'(oReady), 32'(tbl[i].er));
            chk($sformatf("tbl[%0d] frame", i), 32'(oFrame), 32'(tbl[i].ef));
        end

        // Fill: five pushes with host stalled, only four fit
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, {8'(k*3+3), 8'(k*3+2), 8'(k*3+1)}, 1'b0, 1'b1, "fill");
            if (k == 3) chk("fill full ready", 32'(oReady), 32'd0);
        end
        for (int k = 0; k < 3; k++) cycle(1'b1, 24'h0f0e0d, 1'b1, 1'b1, "fill drain1");
        chk("fill ready after pop", 32'(oReady), 32'd1);
        cycle(1'b1, 24'h0f0e0d, 1'b1, 1'b1, "fill push5");
        drain("fill order");

        // Push coincident with the last-word pop at count 1
        cycle(1'b1, 24'hA3A2A1, 1'b1, 1'b1, "coin");
        cycle(1'b0, '0, 1'b1, 1'b1, "coin");
        cycle(1'b0, '0, 1'b1, 1'b1, "coin");
        cycle(1'b1, 24'hB3B2B1, 1'b1, 1'b1, "coin");
        chk("coin valid held", 32'(oValid), 32'd1);
        chk("coin next lane0", 32'(oData), 32'hB1);
        drain("coin");

        // Streaming eight vectors, one word per cycle
        begin
            int pushed;
            logic [15:0] f0;
            pushed = 0;
            f0 = mframe;
            for (int c = 0; c < 26; c++) begin
                bit acc;
                acc = (pushed < 8) && (mq.size() < 4);
                cycle(pushed < 8, 24'($urandom), 1'b1, 1'b1, "stream");
                if (acc) pushed++;
                if (c < 24) chk($sformatf("stream gap c%0d", c), 32'(oValid), 32'd1);
            end
            chk("stream frames", 32'(oFrame), 32'(16'(f0 + 16'd8)));
        end

        // Randomized traffic
        for (int c = 0; c < 400; c++)
            cycle(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'b1, "rand");
        drain("rand");

        // Reset mid-frame, after lane 1 of the second frame
        cycle(1'b1, 24'hC3C2C1, 1'b1, 1'b1, "rstmid");
        cycle(1'b1, 24'hD3D2D1, 1'b1, 1'b1, "rstmid");
        cycle(1'b0, '0, 1'b1, 1'b1, "rstmid");
        cycle(1'b0, '0, 1'b1, 1'b1, "rstmid");
        cycle(1'b0, '0, 1'b1, 1'b1, "rstmid");
        chk("rstmid pre index", 32'(oIndex), 32'd1);
        #2 iRST = 1'b0;
        #1;
        model_reset();
        check_model("rstmid async");
        #1 iRST = 1'b1;
        cycle(1'b1, 24'hE3E2E1, 1'b0, 1'b1, "rstmid after");
        chk("rstmid lane0", 32'(oData), 32'hE1);
        drain("rstmid");

        // Frame counter wrap
        force dut.r_frame = 16'hFFFF;
        #1 release dut.r_frame;
        mframe = 16'hFFFF;
        chk("wrap preload", 32'(oFrame), 32'hFFFF);
        cycle(1'b1, 24'hF3F2F1, 1'b1, 1'b1, "wrap");
        cycle(1'b0, '0, 1'b1, 1'b1, "wrap");
        cycle(1'b0, '0, 1'b1, 1'b1, "wrap");
        chk("wrap before last", 32'(oFrame), 32'hFFFF);
        cycle(1'b0, '0, 1'b1, 1'b1, "wrap");
        chk("wrap to zero", 32'(oFrame), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
